l2t_sii_req_rcv: RTL and testbench
==================================

// Module: l2t_sii_req_rcv
// PURPOSE
//  L2T-side receiver for the SII->L2T inbound request port. Deserializes the 32-bit
//  request packets, buffers headers in an input queue (IQ) and WRI/WR8 payload, and
//  hands them to the L2 pipe over a valid/ready interface. Returns the
//  l2t_sii_iq_dequeue / l2t_sii_wib_dequeue credits to SII.
//  One instance per L2 tag bank (l2t0..l2t7).
// PARAMETERS
//  IQ_DEPTH   4  input-queue entries (power of 2, >=2)
//  WIB_DEPTH  2  64-byte write-buffer entries, WRI only (power of 2, >=1)
// PORTS
//  iol2clk              in   1    clock; all logic on the rising edge
//  arst_l               in   1    asynchronous active-low reset
//  sii_l2t_req_vld      in   1    first (header) cycle of a packet
//  sii_l2t_req          in   32   packet beat
//  l2t_sii_iq_dequeue   out  1    1-cycle pulse: one IQ entry consumed
//  l2t_sii_wib_dequeue  out  1    1-cycle pulse: one WRI 64B buffer released
//  deq_vld              out  1    IQ head valid
//  deq_rdy              in   1    L2 pipe accepts head
//  deq_cmd              out  4    opes of head
//  deq_cfg              out  3    config field
//  deq_tag              out  14   request tag
//  deq_addr             out  40   physical address
//  deq_data             out  512  WRI: 64B; WR8: [63:0], upper bits 0; RD: all 0
//  proto_err            out  1    1-cycle pulse: bad opes or req_vld mid-packet
//  ovf_err              out  1    sticky: commit attempted with IQ/WIB full
// BEHAVIOUR
//  Header beat (req_vld=1): opes=[30:27], cfg=[26:24], tag=[21:8], addr[39:32]=[7:0].
//   Bits [31],[23:22] are ignored.
//  Beat 2 is addr[31:0]. Payload beats follow, with the count set by opes:
//   RD=4'b0001 -> 2 pad beats, ignored.
//   WR8=4'b0100 -> 2 data beats, first beat is [63:32].
//   WRI=4'b0010 -> 16 data beats, MSW first.
//  FSM: IDLE -> ADDR (on req_vld with a legal opes) -> PAYLOAD -> IDLE after the last
//   beat.
//   Beat counter is 4 bits; PAYLOAD exits when count == len-1.
//  Illegal opes in IDLE: proto_err pulses and the FSM stays in IDLE.
//  req_vld while in ADDR or PAYLOAD:
//   - proto_err pulses;
//   - the partial packet is discarded;
//   - the new header is taken and the FSM goes to ADDR.
//  Commit at the last payload beat:
//   - pushes {cmd,cfg,tag,addr}; a WRI also allocates a WIB slot.
//   - If the IQ is full, or the WIB is full for a WRI, the packet is dropped and
//     ovf_err sets.
//   - A pop in the same cycle frees its slot first, so commit succeeds when full.
//  Pop when deq_vld & deq_rdy:
//   - l2t_sii_iq_dequeue pulses the next cycle (registered).
//   - If the head is a WRI, l2t_sii_wib_dequeue pulses in that same cycle.
//  Outputs are a registered FIFO head; deq_* are stable while deq_vld & !deq_rdy.
//  Empty: deq_vld=0. Pointers wrap modulo depth; full/empty use an extra pointer MSB.
//  Latency: deq_vld rises 1 cycle after the committing beat.
//  Minimum RD: 4 cycles header-to-queue, 5 to deq_vld.
//  Reset (async, any time, including mid-packet):
//   - FSM=IDLE; counters and pointers = 0.
//   - deq_vld, both dequeue pulses, proto_err and ovf_err = 0; deq_* data = 0.
//   - Partial packets and queued entries are lost.
// STRUCTURE
//  Package l2t_sii_pkg holds:
//   - OPES_RD/WRI/WR8 constants and the field bit positions;
//   - per-opes beat lengths;
//   - a typedef for the IQ entry struct {cmd,cfg,tag,addr} and the FSM state enum.
//  Sub-module l2t_sii_fifo: generic sync FIFO (WIDTH, DEPTH, push/pop, full/empty,
//  simultaneous push+pop on full), instantiated twice.
//   - IQ: entry plus a 64-bit WR8 field.
//   - WIB: 512-bit data.
//  Deserializer and FSM live in the top module.
// TESTING
//  1 RD: header opes=0001, tag=0x1A5, addr=0x12_3456_7880, then 2 pad beats, deq_rdy=1
//    -> deq_vld at cycle 5 with those fields, deq_data=0; iq_dequeue pulses 1 cycle
//    later; no wib_dequeue.
//  2 WRI: 16 beats 0x0..0xF with deq_rdy=1
//    -> deq_data={0x0,...,0xF} MSW first; iq_dequeue and wib_dequeue pulse in the same
//    cycle.
//  3 Fill: 4 RDs with deq_rdy=0, then a 5th RD -> ovf_err=1; 5th dropped; 4 entries
//    pop in order.
//  4 Commit/pop on full: IQ full; raise deq_rdy on the last beat of a 5th RD
//    -> no ovf_err; 4 entries remain.
//  5 Abort: req_vld during beat 5 of a WRI -> proto_err pulse; first WRI absent; second
//    packet delivered.
//  6 Illegal opes=1111 -> proto_err, nothing queued.
//    arst_l low mid-WRI -> all outputs 0 immediately; next RD works.

Source files
------------

// File: rtl/l2t_sii_pkg.sv
// l2t_sii_pkg: shared constants and types for the SII->L2T request receiver.
//  - opes encodings and header field bit positions
//  - payload beat counts per opes (beats after the address beat)
//  - IQ entry struct and receiver FSM state enum
package l2t_sii_pkg;

  localparam logic [3:0] OPES_RD  = 4'b0001;
  localparam logic [3:0] OPES_WRI = 4'b0010;
  localparam logic [3:0] OPES_WR8 = 4'b0100;

  // Header beat layout. Bits [31] and [23:22] carry nothing for L2T.
  localparam int OPES_HI  = 30;
  localparam int OPES_LO  = 27;
  localparam int CFG_HI   = 26;
  localparam int CFG_LO   = 24;
  localparam int TAG_HI   = 21;
  localparam int TAG_LO   = 8;
  localparam int ADDRH_HI = 7;
  localparam int ADDRH_LO = 0;

  // Payload beats following the address beat.
  localparam int LEN_RD  = 2;   // pad beats
  localparam int LEN_WR8 = 2;   // 64-bit data, MSW first
  localparam int LEN_WRI = 16;  // 64-byte data, MSW first

  localparam int WR8_W = 64;
  localparam int WIB_W = 512;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [2:0]  cfg;
    logic [13:0] tag;
    logic [39:0] addr;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  function automatic logic opes_legal(input logic [3:0] opes);
    return (opes == OPES_RD) || (opes == OPES_WRI) || (opes == OPES_WR8);
  endfunction

  // Value of the 4-bit payload beat counter on the final payload beat.
  function automatic logic [3:0] last_beat(input logic [3:0] opes);
    logic [3:0] last;
    case (opes)
      OPES_WRI: last = 4'(LEN_WRI - 1);
      OPES_WR8: last = 4'(LEN_WR8 - 1);
      default:  last = 4'(LEN_RD - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/l2t_sii_fifo.sv
// l2t_sii_fifo: generic synchronous FIFO.
//  clk, rst_n          clock, asynchronous active-low reset
//  push, push_data     write request; accepted when not full, or when full and a
//                      pop is accepted in the same cycle
//  pop                 read request; ignored when empty
//  pop_data            head entry, forced to 0 while empty
//  full, empty         status from pointers carrying one extra wrap bit
module l2t_sii_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Masking keeps the index at 0 for a single-entry FIFO.
  assign wr_idx = IW'(wr_ptr_q) & IW'(DEPTH - 1);
  assign rd_idx = IW'(rd_ptr_q) & IW'(DEPTH - 1);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/l2t_sii_req_rcv.sv
// l2t_sii_req_rcv: L2T-side receiver for SII inbound requests.
//  iol2clk, arst_l       clock, asynchronous active-low reset
//  sii_l2t_req_vld       marks the header beat of a packet
//  sii_l2t_req[31:0]     packet beat
//  l2t_sii_iq_dequeue    registered pulse, one IQ entry consumed
//  l2t_sii_wib_dequeue   registered pulse, one WRI 64B buffer released
//  deq_vld / deq_rdy     head handshake to the L2 pipe
//  deq_cmd/cfg/tag/addr  head request fields
//  deq_data[511:0]       WRI data, WR8 data in [63:0], or 0 for RD
//  proto_err             registered pulse: illegal opes or header mid-packet
//  ovf_err               sticky: a packet was dropped for lack of IQ/WIB space
//  dbg_state             receiver FSM state
//
// Handshake: a head entry is transferred on every rising edge where
// deq_vld & deq_rdy; while deq_vld & !deq_rdy the deq_* outputs hold steady.
module l2t_sii_req_rcv
  import l2t_sii_pkg::*;
#(
  parameter int IQ_DEPTH  = 4,
  parameter int WIB_DEPTH = 2
) (
  input  logic         iol2clk,
  input  logic         arst_l,
  input  logic         sii_l2t_req_vld,
  input  logic [31:0]  sii_l2t_req,
  output logic         l2t_sii_iq_dequeue,
  output logic         l2t_sii_wib_dequeue,
  output logic         deq_vld,
  input  logic         deq_rdy,
  output logic [3:0]   deq_cmd,
  output logic [2:0]   deq_cfg,
  output logic [13:0]  deq_tag,
  output logic [39:0]  deq_addr,
  output logic [511:0] deq_data,
  output logic         proto_err,
  output logic         ovf_err,
  output state_e       dbg_state
);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     cmd_q;
  logic [2:0]     cfg_q;
  logic [13:0]    tag_q;
  logic [7:0]     addr_hi_q;
  logic [31:0]    addr_lo_q;
  logic [479:0]   sr_q;

  logic           hdr_legal, hdr_load, addr_load, shift_en, commit, proto_err_d;
  logic           is_wri, iq_room, wib_room, commit_ok;
  logic           iq_push, iq_pop, wib_push, wib_pop;
  logic           iq_full, iq_empty, wib_full, wib_empty;
  iq_entry_t      push_entry, head_entry;
  logic [63:0]    push_wr8, head_wr8;
  logic [511:0]   push_wib, head_wib;

  assign hdr_legal = opes_legal(sii_l2t_req[OPES_HI:OPES_LO]);
  assign dbg_state = state_q;

  // ---------------- FSM ----------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_load    = 1'b0;
    addr_load   = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    proto_err_d = 1'b0;
    if (sii_l2t_req_vld) begin
      // A header always restarts the receiver; any packet in flight is dropped.
      cnt_d = '0;
      if (state_q != ST_IDLE) proto_err_d = 1'b1;
      if (hdr_legal) begin
        hdr_load = 1'b1;
        state_d  = ST_ADDR;
      end else begin
        proto_err_d = 1'b1;
        state_d     = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ADDR: begin
          addr_load = 1'b1;
          cnt_d     = '0;
          state_d   = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          shift_en = 1'b1;
          if (cnt_q == last_beat(cmd_q)) begin
            commit  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iol2clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      cfg_q     <= '0;
      tag_q     <= '0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hdr_load) begin
        cmd_q     <= sii_l2t_req[OPES_HI:OPES_LO];
        cfg_q     <= sii_l2t_req[CFG_HI:CFG_LO];
        tag_q     <= sii_l2t_req[TAG_HI:TAG_LO];
        addr_hi_q <= sii_l2t_req[ADDRH_HI:ADDRH_LO];
      end
      if (addr_load) addr_lo_q <= sii_l2t_req;
    end
  end

  // Payload shifts in MSW first; the final beat joins directly at commit,
  // so only 15 words need storing.
  always_ff @(posedge iol2clk) begin
    if (shift_en) sr_q <= {sr_q[447:0], sii_l2t_req};
  end

  // ---------------- commit ----------------
  assign is_wri    = (cmd_q == OPES_WRI);
  assign iq_pop    = deq_vld && deq_rdy;
  assign wib_pop   = iq_pop && (head_entry.cmd == OPES_WRI) && !wib_empty;
  // A pop in the same cycle frees its slot, so a full queue can still accept.
  assign iq_room   = !iq_full || iq_pop;
  assign wib_room  = !wib_full || wib_pop;
  assign commit_ok = commit && iq_room && (!is_wri || wib_room);
  assign iq_push   = commit_ok;
  assign wib_push  = commit_ok && is_wri;

  assign push_entry = '{cmd: cmd_q, cfg: cfg_q, tag: tag_q, addr: {addr_hi_q, addr_lo_q}};
  assign push_wr8   = (cmd_q == OPES_WR8) ? {sr_q[31:0], sii_l2t_req} : '0;
  assign push_wib   = {sr_q, sii_l2t_req};

  l2t_sii_fifo #(
    .WIDTH (IQ_ENTRY_W + WR8_W),
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk       (iol2clk),
    .rst_n     (arst_l),
    .push      (iq_push),
    .push_data ({push_entry, push_wr8}),
    .pop       (iq_pop),
    .pop_data  ({head_entry, head_wr8}),
    .full      (iq_full),
    .empty     (iq_empty)
  );

  l2t_sii_fifo #(
    .WIDTH (WIB_W),
    .DEPTH (WIB_DEPTH)
  ) u_wib (
    .clk       (iol2clk),
    .rst_n     (arst_l),
    .push      (wib_push),
    .push_data (push_wib),
    .pop       (wib_pop),
    .pop_data  (head_wib),
    .full      (wib_full),
    .empty     (wib_empty)
  );

  // ---------------- head outputs ----------------
  assign deq_vld  = !iq_empty;
  assign deq_cmd  = head_entry.cmd;
  assign deq_cfg  = head_entry.cfg;
  assign deq_tag  = head_entry.tag;
  assign deq_addr = head_entry.addr;

  always_comb begin
    deq_data = '0;
    case (head_entry.cmd)
      OPES_WRI: deq_data = head_wib;
      OPES_WR8: deq_data = {448'b0, head_wr8};
      default:  deq_data = '0;
    endcase
  end

  always_ff @(posedge iol2clk or negedge arst_l) begin
    if (!arst_l) begin
      l2t_sii_iq_dequeue  <= 1'b0;
      l2t_sii_wib_dequeue <= 1'b0;
      proto_err           <= 1'b0;
      ovf_err             <= 1'b0;
    end else begin
      l2t_sii_iq_dequeue  <= iq_pop;
      l2t_sii_wib_dequeue <= wib_pop;
      proto_err           <= proto_err_d;
      if (commit && !commit_ok) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2t_sii_req_rcv.sv
// tb_l2t_sii_req_rcv: directed bench for the SII->L2T request receiver.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_l2t_sii_req_rcv;

  logic         iol2clk = 1'b0;
  logic         arst_l = 1'b0;
  logic         sii_l2t_req_vld = 1'b0;
  logic [31:0]  sii_l2t_req = '0;
  logic         deq_rdy = 1'b0;
  logic         l2t_sii_iq_dequeue, l2t_sii_wib_dequeue;
  logic         deq_vld;
  logic [3:0]   deq_cmd;
  logic [2:0]   deq_cfg;
  logic [13:0]  deq_tag;
  logic [39:0]  deq_addr;
  logic [511:0] deq_data;
  logic         proto_err, ovf_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // ---------------- clock/reset ----------------
  always #5 iol2clk = ~iol2clk;

  l2t_sii_req_rcv dut (
    .iol2clk             (iol2clk),
    .arst_l              (arst_l),
    .sii_l2t_req_vld     (sii_l2t_req_vld),
    .sii_l2t_req         (sii_l2t_req),
    .l2t_sii_iq_dequeue  (l2t_sii_iq_dequeue),
    .l2t_sii_wib_dequeue (l2t_sii_wib_dequeue),
    .deq_vld             (deq_vld),
    .deq_rdy             (deq_rdy),
    .deq_cmd             (deq_cmd),
    .deq_cfg             (deq_cfg),
    .deq_tag             (deq_tag),
    .deq_addr            (deq_addr),
    .deq_data            (deq_data),
    .proto_err           (proto_err),
    .ovf_err             (ovf_err),
    .dbg_state           (dbg_state)
  );

  task automatic do_reset();
    @(posedge iol2clk); #1;
    arst_l = 1'b0;
    deq_rdy = 1'b0;
    sii_l2t_req_vld = 1'b0;
    sii_l2t_req = '0;
    exp_q.delete();
    repeat (2) @(posedge iol2clk);
    #1 arst_l = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] hdr(input logic [3:0] op, input logic [2:0] cfg,
                                      input logic [13:0] tag, input logic [7:0] ahi);
    return {1'b0, op, cfg, 2'b00, tag, ahi};
  endfunction

  // Present one beat for one rising edge; returns 1ns after that edge.
  task automatic beat(input logic v, input logic [31:0] d);
    sii_l2t_req_vld = v;
    sii_l2t_req = d;
    @(posedge iol2clk); #1;
    sii_l2t_req_vld = 1'b0;
    sii_l2t_req = '0;
  endtask

  task automatic send_rd(input logic [13:0] tag, input logic [39:0] addr);
    beat(1'b1, hdr(4'b0001, 3'd0, tag, addr[39:32]));
    beat(1'b0, addr[31:0]);
    beat(1'b0, 32'h5555_5555);
    beat(1'b0, 32'h5555_5555);
  endtask

  // Pop n entries, checking each head tag against the scoreboard.
  task automatic drain(input int n, input string name);
    logic [13:0] t;
    deq_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      t = exp_q.pop_front();
      checks++;
      if ({deq_vld, deq_tag} !== {1'b1, t}) begin
        errors++;
        $display("FAIL %s head%0d: got vld=%b tag=%h, need vld=1 tag=%h", name, i, deq_vld, deq_tag, t);
      end
      @(posedge iol2clk); #1;
    end
    deq_rdy = 1'b0;
    checks++;
    if (deq_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s empty_after_drain: got vld=%b, need 0", name, deq_vld);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_l = 1'b0;
    #2;
    checks++;
    if ({deq_vld, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, proto_err, ovf_err, dbg_state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got vld=%b iq=%b wib=%b perr=%b ovf=%b st=%0d, need all 0",
               deq_vld, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, proto_err, ovf_err, dbg_state);
    end
    checks++;
    if ({deq_cmd, deq_cfg, deq_tag, deq_addr} !== 61'b0 || deq_data !== 512'b0) begin
      errors++;
      $display("FAIL reset_data: got cmd=%h cfg=%h tag=%h addr=%h, need 0", deq_cmd, deq_cfg, deq_tag, deq_addr);
    end
    repeat (2) @(posedge iol2clk);
    #1 arst_l = 1'b1;
  endtask

  task automatic test_rd();
    deq_rdy = 1'b1;
    beat(1'b1, hdr(4'b0001, 3'd5, 14'h1A5, 8'h12));
    beat(1'b0, 32'h3456_7880);
    beat(1'b0, 32'hFFFF_FFFF);
    checks++;
    if (deq_vld !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_vld: got %b, need 0", deq_vld);
    end
    beat(1'b0, 32'hAAAA_AAAA);
    checks++;
    if ({deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr} !== {1'b1, 4'h1, 3'h5, 14'h1A5, 40'h12_3456_7880}) begin
      errors++;
      $display("FAIL rd_head: got vld=%b cmd=%h cfg=%h tag=%h addr=%h, need 1/1/5/1a5/1234567880",
               deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr);
    end
    checks++;
    if (deq_data !== 512'b0 || l2t_sii_iq_dequeue !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: got data_lo=%h iq=%b, need 0/0", deq_data[63:0], l2t_sii_iq_dequeue);
    end
    @(posedge iol2clk); #1;
    deq_rdy = 1'b0;
    checks++;
    if ({l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, deq_vld} !== 3'b100) begin
      errors++;
      $display("FAIL rd_dequeue: got iq=%b wib=%b vld=%b, need 1/0/0",
               l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, deq_vld);
    end
    @(posedge iol2clk); #1;
    checks++;
    if (l2t_sii_iq_dequeue !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse_width: got iq=%b, need 0", l2t_sii_iq_dequeue);
    end
  endtask

  task automatic test_wri();
    logic [511:0] exp_d;
    for (int i = 0; i < 16; i++) exp_d[511 - 32*i -: 32] = 32'(i);
    deq_rdy = 1'b1;
    beat(1'b1, hdr(4'b0010, 3'd2, 14'h3C0F, 8'hAB));
    beat(1'b0, 32'hCAFE_0040);
    for (int i = 0; i < 16; i++) beat(1'b0, 32'(i));
    checks++;
    if ({deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr} !== {1'b1, 4'h2, 3'h2, 14'h3C0F, 40'hAB_CAFE_0040}) begin
      errors++;
      $display("FAIL wri_head: got vld=%b cmd=%h cfg=%h tag=%h addr=%h, need 1/2/2/3c0f/abcafe0040",
               deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr);
    end
    checks++;
    if (deq_data !== exp_d) begin
      errors++;
      $display("FAIL wri_data: got top=%h bottom=%h, need top=%h bottom=%h",
               deq_data[511:448], deq_data[63:0], exp_d[511:448], exp_d[63:0]);
    end
    @(posedge iol2clk); #1;
    deq_rdy = 1'b0;
    checks++;
    if ({l2t_sii_iq_dequeue, l2t_sii_wib_dequeue} !== 2'b11) begin
      errors++;
      $display("FAIL wri_dequeue: got iq=%b wib=%b, need 1/1", l2t_sii_iq_dequeue, l2t_sii_wib_dequeue);
    end
  endtask

  task automatic test_wr8();
    deq_rdy = 1'b0;
    beat(1'b1, hdr(4'b0100, 3'd7, 14'h0777, 8'h01));
    beat(1'b0, 32'h0000_1000);
    beat(1'b0, 32'hDEAD_BEEF);
    beat(1'b0, 32'h0123_4567);
    repeat (2) @(posedge iol2clk);
    #1;
    checks++;
    if ({deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr} !== {1'b1, 4'h4, 3'h7, 14'h0777, 40'h01_0000_1000} ||
        deq_data !== {448'b0, 64'hDEAD_BEEF_0123_4567}) begin
      errors++;
      $display("FAIL wr8_head: got vld=%b cmd=%h tag=%h addr=%h data_lo=%h, need 1/4/0777/0100001000/deadbeef01234567",
               deq_vld, deq_cmd, deq_tag, deq_addr, deq_data[63:0]);
    end
    deq_rdy = 1'b1;
    @(posedge iol2clk); #1;
    deq_rdy = 1'b0;
    checks++;
    if ({l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, deq_vld} !== 3'b100) begin
      errors++;
      $display("FAIL wr8_dequeue: got iq=%b wib=%b vld=%b, need 1/0/0",
               l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, deq_vld);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_rd(14'h100 + 14'(i), 40'h00_0000_1000 + 40'(i));
      exp_q.push_back(14'h100 + 14'(i));
    end
    checks++;
    if ({deq_vld, ovf_err} !== 2'b10) begin
      errors++;
      $display("FAIL fill_4: got vld=%b ovf=%b, need 1/0", deq_vld, ovf_err);
    end
    send_rd(14'h200, 40'h00_0000_2000);
    checks++;
    if (ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL fill_ovf: got ovf=%b, need 1", ovf_err);
    end
    drain(4, "fill");
  endtask

  task automatic test_commit_on_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_rd(14'h300 + 14'(i), 40'h00_0000_3000 + 40'(i));
      exp_q.push_back(14'h300 + 14'(i));
    end
    beat(1'b1, hdr(4'b0001, 3'd0, 14'h304, 8'h00));
    beat(1'b0, 32'h0000_3004);
    beat(1'b0, 32'h0);
    deq_rdy = 1'b1;
    beat(1'b0, 32'h0);
    deq_rdy = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(14'h304);
    checks++;
    if ({ovf_err, l2t_sii_iq_dequeue} !== 2'b01) begin
      errors++;
      $display("FAIL full_commit: got ovf=%b iq=%b, need 0/1", ovf_err, l2t_sii_iq_dequeue);
    end
    drain(4, "full");
  endtask

  task automatic test_abort();
    do_reset();
    beat(1'b1, hdr(4'b0010, 3'd0, 14'h0AAA, 8'h00));
    beat(1'b0, 32'h0000_4000);
    beat(1'b0, 32'h1111_1111);
    beat(1'b0, 32'h2222_2222);
    beat(1'b1, hdr(4'b0001, 3'd1, 14'h002B, 8'h05));
    checks++;
    if ({proto_err, dbg_state} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL abort_perr: got perr=%b st=%0d, need 1/1", proto_err, dbg_state);
    end
    beat(1'b0, 32'h0000_0100);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_perr_width: got %b, need 0", proto_err);
    end
    beat(1'b0, 32'h0);
    beat(1'b0, 32'h0);
    checks++;
    if ({deq_vld, deq_cmd, deq_cfg, deq_tag, deq_addr} !== {1'b1, 4'h1, 3'h1, 14'h002B, 40'h05_0000_0100}) begin
      errors++;
      $display("FAIL abort_head: got vld=%b cmd=%h tag=%h addr=%h, need 1/1/002b/0500000100",
               deq_vld, deq_cmd, deq_tag, deq_addr);
    end
    deq_rdy = 1'b1;
    @(posedge iol2clk); #1;
    deq_rdy = 1'b0;
    repeat (3) @(posedge iol2clk);
    #1;
    checks++;
    if ({deq_vld, dbg_state} !== 3'b000) begin
      errors++;
      $display("FAIL abort_residue: got vld=%b st=%0d, need 0/0", deq_vld, dbg_state);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    beat(1'b1, hdr(4'b1111, 3'd0, 14'h0123, 8'h00));
    checks++;
    if ({proto_err, dbg_state} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL illegal_perr: got perr=%b st=%0d, need 1/0", proto_err, dbg_state);
    end
    for (int i = 0; i < 4; i++) beat(1'b0, 32'h7777_0000 + 32'(i));
    checks++;
    if ({deq_vld, proto_err} !== 2'b00) begin
      errors++;
      $display("FAIL illegal_queued: got vld=%b perr=%b, need 0/0", deq_vld, proto_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_rd(14'h0011, 40'h00_0000_0011);
    beat(1'b1, hdr(4'b0010, 3'd0, 14'h0012, 8'h00));
    beat(1'b0, 32'h0000_5000);
    beat(1'b0, 32'h1);
    beat(1'b0, 32'h2);
    checks++;
    if ({deq_vld, dbg_state} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL mid_before: got vld=%b st=%0d, need 1/2", deq_vld, dbg_state);
    end
    #2 arst_l = 1'b0;
    #1;
    checks++;
    if ({deq_vld, l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, proto_err, ovf_err, dbg_state} !== 7'b0 ||
        {deq_cmd, deq_cfg, deq_tag, deq_addr} !== 61'b0 || deq_data !== 512'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b st=%0d tag=%h addr=%h, need all 0", deq_vld, dbg_state, deq_tag, deq_addr);
    end
    @(posedge iol2clk); #1;
    arst_l = 1'b1;
    send_rd(14'h0013, 40'h7F_0000_0013);
    checks++;
    if ({deq_vld, deq_cmd, deq_tag, deq_addr} !== {1'b1, 4'h1, 14'h0013, 40'h7F_0000_0013}) begin
      errors++;
      $display("FAIL mid_after: got vld=%b cmd=%h tag=%h addr=%h, need 1/1/0013/7f00000013",
               deq_vld, deq_cmd, deq_tag, deq_addr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rd();
    test_wri();
    test_wr8();
    test_fill();
    test_commit_on_full();
    test_abort();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
